// File: rtl/rl_ram_fifo_pkg.sv
// Shared constants for the RAM-backed FWFT FIFO and its output buffer.
package rl_ram_fifo_pkg;

    // The output buffer is two entries deep: enough to cover one RAM read in flight
    // while the consumer pops every cycle.
    localparam int unsigned OB_DEPTH = 2;
    localparam int unsigned OB_CW    = $clog2(OB_DEPTH + 1);

endpackage

// File: rtl/rl_ram_fifo_if.sv
// Producer/consumer bus of rl_ram_fifo. The system side uses master and the FIFO uses slave.
interface rl_ram_fifo_if #(
    parameter int unsigned ABITS = 10,
    parameter int unsigned DBITS = 32
);

    logic             clr_i;
    logic             wr_i;
    logic [DBITS-1:0] din_i;
    logic             full_o;
    logic             rd_i;
    logic [DBITS-1:0] dout_o;
    logic             valid_o;
    logic [ABITS+1:0] level_o;
    logic             ovf_o;
    logic             unf_o;

    modport master (
        output clr_i, wr_i, din_i, rd_i,
        input  full_o, dout_o, valid_o, level_o, ovf_o, unf_o
    );

    modport slave (
        input  clr_i, wr_i, din_i, rd_i,
        output full_o, dout_o, valid_o, level_o, ovf_o, unf_o
    );

endinterface

// File: rtl/rl_fifo_outbuf.sv
// Two-entry register FIFO that presents the registered head word to the consumer.
module rl_fifo_outbuf
    import rl_ram_fifo_pkg::*;
#(
    parameter int unsigned DBITS = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             push,
    input  logic [DBITS-1:0] din,
    input  logic             pop,
    output logic [DBITS-1:0] dout,
    output logic [OB_CW-1:0] cnt
);

    logic [DBITS-1:0] r_q0;
    logic [DBITS-1:0] r_q1;
    logic [OB_CW-1:0] r_cnt;

    // r_q0 is always the head. On a pop, r_q1 shifts into r_q0 and new data fills the tail.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_q0  <= '0;
            r_q1  <= '0;
            r_cnt <= '0;
        end else if (clr_i) begin
            r_q0  <= '0;
            r_q1  <= '0;
            r_cnt <= '0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (r_cnt == '0) r_q0 <= din;
                    else             r_q1 <= din;
                    r_cnt <= r_cnt + OB_CW'(1);
                end
                2'b01: begin
                    r_q0  <= r_q1;
                    r_cnt <= r_cnt - OB_CW'(1);
                end
                2'b11: begin
                    if (r_cnt == OB_CW'(1)) begin
                        r_q0 <= din;
                    end else begin
                        r_q0 <= r_q1;
                        r_q1 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dout = r_q0;
    assign cnt  = r_cnt;

endmodule

// File: rtl/rl_ram_1r1w.sv
// 1R1W RAM with byte enables. The read data is registered and returns 1 cycle after re_i.
// A same-address read and write returns the newly written data (write-first).
module rl_ram_1r1w #(
    parameter int unsigned ABITS = 10,
    parameter int unsigned DBITS = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     we_i,
    input  logic [ABITS-1:0]         waddr_i,
    input  logic [DBITS-1:0]         wdata_i,
    input  logic [(DBITS+7)/8-1:0]   be_i,
    input  logic                     re_i,
    input  logic [ABITS-1:0]         raddr_i,
    output logic [DBITS-1:0]         rdata_o
);

    localparam int unsigned DEPTH = 2 ** ABITS;

    logic [DBITS-1:0] r_mem [DEPTH];
    logic [DBITS-1:0] r_rdata;
    logic [DBITS-1:0] w_bmask;
    logic [DBITS-1:0] w_wmerged;

    // Expand the byte enables to a per-bit mask.
    for (genvar b = 0; b < DBITS; b++) begin : g_mask
        assign w_bmask[b] = be_i[b/8];
    end

    assign w_wmerged = (r_mem[waddr_i] & ~w_bmask) | (wdata_i & w_bmask);

    // Storage array. It has no reset, so its contents survive rst_ni.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            r_mem[waddr_i] <= w_wmerged;
        end
    end

    // Registered read port, with write-first bypass on an address collision.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rdata <= '0;
        end else if (re_i) begin
            r_rdata <= (we_i && (raddr_i == waddr_i)) ? w_wmerged : r_mem[raddr_i];
        end
    end

    assign rdata_o = r_rdata;

endmodule

// File: rtl/rl_ram_fifo.sv
// First-word-fall-through FIFO built on rl_ram_1r1w. This level owns the RAM
// pointers, the occupancy count, the read-in-flight flag and the error pulses.
module rl_ram_fifo
    import rl_ram_fifo_pkg::*;
#(
    parameter int unsigned ABITS = 10,
    parameter int unsigned DBITS = 32
) (
    input  logic           clk_i,
    input  logic           rst_i,
    rl_ram_fifo_if.slave   bus
);

    localparam int unsigned DEPTH = 2 ** ABITS;
    localparam int unsigned CW    = ABITS + 1;
    localparam int unsigned LW    = ABITS + 2;
    localparam int unsigned OW    = OB_CW + 1;

    logic [ABITS-1:0] r_wptr;
    logic [ABITS-1:0] r_rptr;
    logic [CW-1:0]    r_ram_cnt;
    logic             r_inflight;
    logic             r_full;
    logic             r_valid;
    logic [LW-1:0]    r_level;
    logic             r_ovf;
    logic             r_unf;

    logic             w_rst_n;
    logic             w_push;
    logic             w_pop;
    logic             w_issue;
    logic [OW-1:0]    w_occ;
    logic [CW-1:0]    w_ram_cnt_nxt;
    logic [OB_CW-1:0] w_out_cnt;
    logic [OB_CW-1:0] w_out_cnt_nxt;
    logic [DBITS-1:0] w_rdata;
    logic [DBITS-1:0] w_ob_dout;

    assign w_rst_n = ~rst_i;
    assign w_push  = bus.wr_i & ~r_full & ~bus.clr_i;
    assign w_pop   = bus.rd_i & r_valid & ~bus.clr_i;

    // Issue a read only when the output buffer can still take the word after this cycle's pop.
    // When ram_cnt is 0, a word pushed this cycle is not read yet, so a same-address read
    // and write never happen together.
    assign w_occ   = OW'(w_out_cnt) + OW'(r_inflight) - OW'(w_pop);
    assign w_issue = ~bus.clr_i & (r_ram_cnt != '0) & (w_occ < OW'(OB_DEPTH));

    assign w_ram_cnt_nxt = r_ram_cnt + CW'(w_push) - CW'(w_issue);
    assign w_out_cnt_nxt = w_out_cnt + OB_CW'(r_inflight) - OB_CW'(w_pop);

    rl_ram_1r1w #(
        .ABITS (ABITS),
        .DBITS (DBITS)
    ) u_ram (
        .clk_i   (clk_i),
        .rst_ni  (w_rst_n),
        .we_i    (w_push),
        .waddr_i (r_wptr),
        .wdata_i (bus.din_i),
        .be_i    ('1),
        .re_i    (w_issue),
        .raddr_i (r_rptr),
        .rdata_o (w_rdata)
    );

    rl_fifo_outbuf #(
        .DBITS (DBITS)
    ) u_outbuf (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (bus.clr_i),
        .push  (r_inflight),
        .din   (w_rdata),
        .pop   (w_pop),
        .dout  (w_ob_dout),
        .cnt   (w_out_cnt)
    );

    // Pointers, occupancy and status flags. A flush discards everything, including a read in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_ram_cnt  <= '0;
            r_inflight <= 1'b0;
            r_full     <= 1'b0;
            r_valid    <= 1'b0;
            r_level    <= '0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
        end else if (bus.clr_i) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_ram_cnt  <= '0;
            r_inflight <= 1'b0;
            r_full     <= 1'b0;
            r_valid    <= 1'b0;
            r_level    <= '0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
        end else begin
            if (w_push)  r_wptr <= r_wptr + ABITS'(1);
            if (w_issue) r_rptr <= r_rptr + ABITS'(1);
            r_ram_cnt  <= w_ram_cnt_nxt;
            r_inflight <= w_issue;
            r_full     <= (w_ram_cnt_nxt == CW'(DEPTH));
            r_valid    <= (w_out_cnt_nxt != '0);
            r_level    <= r_level + LW'(w_push) - LW'(w_pop);
            r_ovf      <= bus.wr_i & r_full;
            r_unf      <= bus.rd_i & ~r_valid;
        end
    end

    assign bus.full_o  = r_full;
    assign bus.valid_o = r_valid;
    assign bus.dout_o  = w_ob_dout;
    assign bus.level_o = r_level;
    assign bus.ovf_o   = r_ovf;
    assign bus.unf_o   = r_unf;

endmodule

// File: tb/tb_rl_ram_fifo.sv
// Directed bench for rl_ram_fifo with ABITS=2 (DEPTH=4) and DBITS=32.
module tb_rl_ram_fifo;

    localparam int unsigned ABITS = 2;
    localparam int unsigned DBITS = 32;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   exp_v;

    rl_ram_fifo_if #(.ABITS(ABITS), .DBITS(DBITS)) bus ();

    rl_ram_fifo #(.ABITS(ABITS), .DBITS(DBITS)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the run stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        bus.clr_i = 1'b0;
        bus.wr_i  = 1'b0;
        bus.rd_i  = 1'b0;
        bus.din_i = '0;
        tick();
        tick();
        chk("rst_full",  64'(bus.full_o),  64'd0);
        chk("rst_valid", 64'(bus.valid_o), 64'd0);
        chk("rst_level", 64'(bus.level_o), 64'd0);
        chk("rst_dout",  64'(bus.dout_o),  64'd0);
        chk("rst_ovf",   64'(bus.ovf_o),   64'd0);
        chk("rst_unf",   64'(bus.unf_o),   64'd0);
        rst = 1'b0;

        // 1: single word latency
        bus.wr_i = 1'b1; bus.din_i = 32'hA0;
        tick();
        bus.wr_i = 1'b0; bus.din_i = '0;
        chk("t1_valid_e0", 64'(bus.valid_o), 64'd0);
        tick();
        chk("t1_valid_e1", 64'(bus.valid_o), 64'd0);
        tick();
        chk("t1_valid_e2", 64'(bus.valid_o), 64'd1);
        chk("t1_dout",     64'(bus.dout_o),  64'hA0);
        chk("t1_level",    64'(bus.level_o), 64'd1);
        bus.rd_i = 1'b1;
        tick();
        bus.rd_i = 1'b0;
        chk("t1_valid_pop", 64'(bus.valid_o), 64'd0);
        chk("t1_level_pop", 64'(bus.level_o), 64'd0);

        // 2: fill to full, then overflow
        for (int i = 1; i <= 6; i++) begin
            bus.wr_i = 1'b1; bus.din_i = 32'(i);
            tick();
        end
        bus.wr_i = 1'b0;
        chk("t2_full",  64'(bus.full_o),  64'd1);
        chk("t2_level", 64'(bus.level_o), 64'd6);
        chk("t2_dout",  64'(bus.dout_o),  64'h1);
        bus.wr_i = 1'b1; bus.din_i = 32'h7;
        tick();
        bus.wr_i = 1'b0;
        chk("t2_ovf",       64'(bus.ovf_o),   64'd1);
        chk("t2_level_ovf", 64'(bus.level_o), 64'd6);
        tick();
        chk("t2_ovf_clear", 64'(bus.ovf_o),   64'd0);
        chk("t2_full_hold", 64'(bus.full_o),  64'd1);

        // 3: drain at full rate
        bus.rd_i = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            chk("t3_valid", 64'(bus.valid_o), 64'd1);
            chk("t3_dout",  64'(bus.dout_o),  64'(k));
            tick();
            if (k == 1) chk("t3_full_drop", 64'(bus.full_o), 64'd0);
        end
        bus.rd_i = 1'b0;
        chk("t3_valid_end", 64'(bus.valid_o), 64'd0);
        chk("t3_level_end", 64'(bus.level_o), 64'd0);

        // 4: streaming across pointer wrap
        exp_v = 0;
        for (int i = 0; i < 20; i++) begin
            bus.wr_i = 1'b1; bus.din_i = 32'(i); bus.rd_i = 1'b1;
            if (bus.valid_o) begin
                chk("t4_dout", 64'(bus.dout_o), 64'(exp_v));
                exp_v++;
            end
            tick();
            if (i == 10) chk("t4_level_steady", 64'(bus.level_o), 64'd3);
        end
        bus.wr_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.valid_o) begin
                chk("t4_dout", 64'(bus.dout_o), 64'(exp_v));
                exp_v++;
            end
            tick();
        end
        bus.rd_i = 1'b0;
        chk("t4_count", 64'(exp_v),         64'd20);
        chk("t4_empty", 64'(bus.valid_o),   64'd0);
        chk("t4_level", 64'(bus.level_o),   64'd0);

        // 5: flush with a read in flight
        for (int i = 0; i < 4; i++) begin
            bus.wr_i = 1'b1; bus.din_i = 32'h40 + 32'(i);
            tick();
        end
        bus.wr_i = 1'b0;
        bus.rd_i = 1'b1;
        tick();
        bus.rd_i = 1'b0;
        chk("t5_pre_level", 64'(bus.level_o), 64'd3);
        chk("t5_pre_dout",  64'(bus.dout_o),  64'h41);
        bus.clr_i = 1'b1; bus.wr_i = 1'b1; bus.rd_i = 1'b1; bus.din_i = 32'h99;
        tick();
        bus.clr_i = 1'b0; bus.wr_i = 1'b0; bus.rd_i = 1'b0;
        chk("t5_clr_valid", 64'(bus.valid_o), 64'd0);
        chk("t5_clr_level", 64'(bus.level_o), 64'd0);
        chk("t5_clr_full",  64'(bus.full_o),  64'd0);
        tick();
        chk("t5_clr_valid2", 64'(bus.valid_o), 64'd0);
        chk("t5_clr_level2", 64'(bus.level_o), 64'd0);
        bus.wr_i = 1'b1; bus.din_i = 32'h55;
        tick();
        bus.wr_i = 1'b0;
        tick();
        chk("t5_55_early", 64'(bus.valid_o), 64'd0);
        tick();
        chk("t5_55_valid", 64'(bus.valid_o), 64'd1);
        chk("t5_55_dout",  64'(bus.dout_o),  64'h55);
        bus.rd_i = 1'b1;
        tick();
        bus.rd_i = 1'b0;
        chk("t5_empty", 64'(bus.valid_o), 64'd0);

        // 6: underflow, then async reset while full
        bus.rd_i = 1'b1;
        tick();
        bus.rd_i = 1'b0;
        chk("t6_unf",       64'(bus.unf_o),   64'd1);
        chk("t6_unf_level", 64'(bus.level_o), 64'd0);
        chk("t6_unf_valid", 64'(bus.valid_o), 64'd0);
        tick();
        chk("t6_unf_clear", 64'(bus.unf_o),   64'd0);
        for (int i = 0; i < 7; i++) begin
            bus.wr_i = 1'b1; bus.din_i = 32'h70 + 32'(i);
            tick();
        end
        bus.wr_i = 1'b0;
        chk("t6_pre_full",  64'(bus.full_o),  64'd1);
        chk("t6_pre_ovf",   64'(bus.ovf_o),   64'd1);
        chk("t6_pre_dout",  64'(bus.dout_o),  64'h70);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_ar_full",  64'(bus.full_o),  64'd0);
        chk("t6_ar_valid", 64'(bus.valid_o), 64'd0);
        chk("t6_ar_level", 64'(bus.level_o), 64'd0);
        chk("t6_ar_dout",  64'(bus.dout_o),  64'd0);
        chk("t6_ar_ovf",   64'(bus.ovf_o),   64'd0);
        chk("t6_ar_unf",   64'(bus.unf_o),   64'd0);
        #1;
        rst = 1'b0;
        tick();
        chk("t6_post_valid", 64'(bus.valid_o), 64'd0);
        chk("t6_post_level", 64'(bus.level_o), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
